// File: rtl/mux_dec_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux_dec_arbiter
// Description : Round-robin arbiter sharing one mux_2x1 -> dec_3x8 path
//               between two requesters. Drives the mux select and the
//               decoder enable with break-before-make sequencing: the select
//               only moves while the decoder is disabled, so the decoded
//               8-line output never glitches between sources.
//
// Parameters  : HOLD_CYCLES - decoder-enable cycles per grant (>= 1)
//
// Ports       : clk      in   1  system clock, rising edge
//               rst      in   1  asynchronous, active-high reset
//               req      in   2  level-sensitive request, one bit per source
//               lock     in   2  (MUX_DEC_LOCK_EN only) extends the
//                                current winner's grant past HOLD_CYCLES
//               mux_sel  out  1  0 = in1 (requester 0), 1 = in2 (requester 1)
//               dec_en   out  1  decoder enable
//               gnt      out  2  one-hot grant, 2'b00 when idle
//               busy     out  1  high whenever the FSM is not idle
//               done     out  1  one-cycle pulse marking grant release
//
// Options     : define MUX_DEC_LOCK_EN to add the lock port and the
//               grant-extension behaviour. Without it every grant is exactly
//               HOLD_CYCLES enable cycles.
//
// Revision    : 1.0 - initial release
// ============================================================================
module mux_dec_arbiter #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
`ifdef MUX_DEC_LOCK_EN
    input  logic [1:0] lock,
`endif
    output logic       mux_sel,
    output logic       dec_en,
    output logic [1:0] gnt,
    output logic       busy,
    output logic       done
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                 c_cnt_w = $clog2(HOLD_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_hold  = c_cnt_w'(HOLD_CYCLES);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETUP   = 2'd1,
        S_ACTIVE  = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic [c_cnt_w-1:0]   w_cnt_inc;
    logic                 r_last;       // winner of the most recent arbitration
    logic                 w_last_nxt;
    logic                 w_winner;
    logic                 w_lock_hold;

    logic                 r_mux_sel;
    logic                 r_dec_en;
    logic [1:0]           r_gnt;
    logic                 r_busy;
    logic                 r_done;
    logic                 w_mux_sel_nxt;
    logic                 w_dec_en_nxt;
    logic [1:0]           w_gnt_nxt;
    logic                 w_busy_nxt;
    logic                 w_done_nxt;

    // ------------------------------------------------------------------------
    // Arbitration: a lone requester always wins; on contention the source
    // that did not win last time gets the path. Only consulted when req!=0.
    // ------------------------------------------------------------------------
    always_comb begin
        w_winner = ~r_last;
        case (req)
            2'b01:   w_winner = 1'b0;
            2'b10:   w_winner = 1'b1;
            default: w_winner = ~r_last;
        endcase
    end

    // Saturating hold counter: once the terminal count is reached it stays
    // there for as long as a lock keeps the grant alive.
    assign w_cnt_inc = (r_cnt == c_hold) ? c_hold : r_cnt + 1'b1;

`ifdef MUX_DEC_LOCK_EN
    // Only the current winner's lock bit matters; r_last holds that winner
    // for the whole grant.
    assign w_lock_hold = lock[r_last];
`else
    assign w_lock_hold = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;

        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_last_nxt  = w_winner;
                    w_state_nxt = S_SETUP;
                end
            end

            S_SETUP: begin
                // Counter starts fresh for every grant.
                w_cnt_nxt   = '0;
                w_state_nxt = S_ACTIVE;
            end

            S_ACTIVE: begin
                // req is deliberately ignored here: a grant always runs to
                // its terminal count.
                w_cnt_nxt = w_cnt_inc;
                if ((w_cnt_inc == c_hold) && !w_lock_hold) begin
                    w_state_nxt = S_RELEASE;
                end
            end

            S_RELEASE: begin
                if (|req) begin
                    w_last_nxt  = w_winner;
                    w_state_nxt = S_SETUP;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output decode. Outputs are registered from the current state, so they
    // trail the state register by one cycle. mux_sel is only reloaded while
    // the SETUP state is decoded, a cycle in which dec_en is forced low; this
    // is what gives the break-before-make ordering.
    // ------------------------------------------------------------------------
    always_comb begin
        w_mux_sel_nxt = r_mux_sel;
        w_dec_en_nxt  = 1'b0;
        w_gnt_nxt     = 2'b00;
        w_busy_nxt    = (r_state != S_IDLE);
        w_done_nxt    = 1'b0;

        case (r_state)
            S_SETUP: begin
                w_mux_sel_nxt = r_last;
                w_gnt_nxt     = r_last ? 2'b10 : 2'b01;
            end
            S_ACTIVE: begin
                w_dec_en_nxt  = 1'b1;
                w_gnt_nxt     = r_last ? 2'b10 : 2'b01;
            end
            S_RELEASE: begin
                w_done_nxt    = 1'b1;
            end
            default: begin
                w_gnt_nxt     = 2'b00;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_last    <= 1'b1;      // requester 0 wins the first contention
            r_mux_sel <= 1'b0;
            r_dec_en  <= 1'b0;
            r_gnt     <= 2'b00;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_last    <= w_last_nxt;
            r_mux_sel <= w_mux_sel_nxt;
            r_dec_en  <= w_dec_en_nxt;
            r_gnt     <= w_gnt_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign mux_sel = r_mux_sel;
    assign dec_en  = r_dec_en;
    assign gnt     = r_gnt;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule
`default_nettype wire
